// File: rtl/axi_line_fetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axi_line_fetch_if
//  Description : AXI4 read-address and read-data channel bundle between the
//                line fetcher (master) and the DDR controller port (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_line_fetch_if #(
    parameter int DQ_WIDTH   = 32,
    parameter int ADDR_WIDTH = 28
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    arready;
    logic [DQ_WIDTH*8-1:0]   rdata;
    logic                    rvalid;
    logic                    rlast;
    logic [1:0]              rresp;
    logic                    rready;

    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rdata, rvalid, rlast, rresp
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rdata, rvalid, rlast, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_line_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axi_line_fetch
//  Description : AXI4 read master fetching one video line per request from
//                DDR (BURST_LEN-beat bursts, one outstanding) and streaming
//                the beats into the HDMI-side line buffer.
//                Optional macro AXI_LINE_FETCH_ERR_CNT_EN builds the
//                error-burst counter behind err_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_line_fetch #(
    parameter int                    DQ_WIDTH   = 32,
    parameter int                    H_WIDTH    = 1280,
    parameter int                    H_HEIGHT   = 720,
    parameter int                    BURST_LEN  = 16,
    parameter int                    ADDR_WIDTH = 28,
    parameter logic [ADDR_WIDTH-1:0] CH_STRIDE  = 'h080_0000
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    frame_start,
    input  wire logic                    line_req,
    input  wire logic [1:0]              channel_sel,
    input  wire logic                    axi_wr_buf_wait,
    output logic                         line_busy,
    output logic                         line_done,
    output logic                         buf_wr_en,
    output logic [DQ_WIDTH*8-1:0]        buf_wr_data,
    output logic                         rd_err,
    output logic                         req_miss,
    output logic [7:0]                   err_cnt,
    axi_line_fetch_if.master             axi
);

    // Line geometry; the line must split into a whole number of bursts.
    localparam int c_DATA_W          = DQ_WIDTH * 8;
    localparam int c_BEAT_BYTES      = DQ_WIDTH;
    localparam int c_LINE_BYTES      = H_WIDTH * 2;
    localparam int c_BEATS_PER_LINE  = c_LINE_BYTES / c_BEAT_BYTES;
    localparam int c_BURSTS_PER_LINE = c_BEATS_PER_LINE / BURST_LEN;
    localparam int c_BURST_BYTES     = BURST_LEN * c_BEAT_BYTES;
    localparam int c_BIDX_W          = $clog2(c_BURSTS_PER_LINE + 1);
    localparam int c_ROW_W           = $clog2(H_HEIGHT + 1);

    localparam logic [c_BIDX_W-1:0] c_LAST_BIDX = c_BIDX_W'(c_BURSTS_PER_LINE - 1);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(H_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DATA  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [1:0]             r_ch_q;
    logic [c_BIDX_W-1:0]    r_burst_idx;
    logic [c_ROW_W-1:0]     r_row_cnt;
    logic                   r_abort;
    logic                   r_arvalid;
    logic [ADDR_WIDTH-1:0]  r_araddr;
    logic                   r_buf_wr_en;
    logic [c_DATA_W-1:0]    r_buf_wr_data;
    logic                   r_rd_err;
    logic                   r_req_miss;

    logic                   w_accept;
    logic                   w_ar_fire;
    logic                   w_ar_raise;
    logic                   w_beat;
    logic                   w_beat_last;
    logic                   w_beat_err;
    logic [ADDR_WIDTH-1:0]  w_addr;

    assign w_accept    = (r_state == S_IDLE) && line_req;
    assign w_ar_fire   = r_arvalid && axi.arready;
    // A new AR is not raised once a frame restart is pending or arriving,
    // so an abort never launches a burst that was not already presented.
    assign w_ar_raise  = (r_state == S_ISSUE) && !r_arvalid && !axi_wr_buf_wait
                         && !r_abort && !frame_start;
    assign w_beat      = (r_state == S_DATA) && axi.rvalid;
    assign w_beat_last = w_beat && axi.rlast;
    assign w_beat_err  = w_beat && (axi.rresp != 2'b00);

    // Burst byte address; wraps silently at ADDR_WIDTH.
    assign w_addr = ADDR_WIDTH'(r_ch_q) * CH_STRIDE
                  + ADDR_WIDTH'(r_row_cnt) * ADDR_WIDTH'(c_LINE_BYTES)
                  + ADDR_WIDTH'(r_burst_idx) * ADDR_WIDTH'(c_BURST_BYTES);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode for the line sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (line_req) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_ar_fire) begin
                    w_state_next = S_DATA;
                end else if (r_abort && !r_arvalid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DATA: begin
                if (w_beat_last) begin
                    w_state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if ((r_burst_idx == c_LAST_BIDX) || r_abort) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_ISSUE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Channel latch and burst index within the current line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_q      <= 2'd0;
            r_burst_idx <= '0;
        end else if (w_accept) begin
            r_ch_q      <= channel_sel;
            r_burst_idx <= '0;
        end else if ((r_state == S_NEXT) && (w_state_next == S_ISSUE)) begin
            r_burst_idx <= r_burst_idx + 1'b1;
        end
    end

    // AR channel: address captured when valid rises, held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
        end else if (w_ar_fire) begin
            r_arvalid <= 1'b0;
        end else if (w_ar_raise) begin
            r_arvalid <= 1'b1;
            r_araddr  <= w_addr;
        end
    end

    // Frame restart seen mid-line: finish the current burst, then end the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_abort <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_abort <= 1'b0;
        end else if (frame_start && (r_state != S_IDLE)) begin
            r_abort <= 1'b1;
        end
    end

    // Row counter: frame_start wins over the end-of-line increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_cnt <= '0;
        end else if (frame_start) begin
            r_row_cnt <= '0;
        end else if ((r_state == S_DONE) && !r_abort) begin
            if (r_row_cnt == c_LAST_ROW) begin
                r_row_cnt <= '0;
            end else begin
                r_row_cnt <= r_row_cnt + 1'b1;
            end
        end
    end

    // Buffer write port: one registered strobe per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_wr_en   <= 1'b0;
            r_buf_wr_data <= '0;
        end else begin
            r_buf_wr_en <= w_beat;
            if (w_beat) begin
                r_buf_wr_data <= axi.rdata;
            end
        end
    end

    // Sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_err   <= 1'b0;
            r_req_miss <= 1'b0;
        end else begin
            if (w_beat_err) begin
                r_rd_err <= 1'b1;
            end
            if (line_req && (r_state != S_IDLE)) begin
                r_req_miss <= 1'b1;
            end
        end
    end

`ifdef AXI_LINE_FETCH_ERR_CNT_EN
    logic       r_burst_err;
    logic [7:0] r_err_cnt;

    // Count bursts carrying at least one non-OKAY beat, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst_err <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            if (w_beat_last) begin
                r_burst_err <= 1'b0;
            end else if (w_beat_err) begin
                r_burst_err <= 1'b1;
            end
            if (frame_start) begin
                r_err_cnt <= 8'd0;
            end else if (w_beat_last && (r_burst_err || w_beat_err)
                         && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign line_busy   = (r_state == S_ISSUE) || (r_state == S_DATA) || (r_state == S_NEXT);
    assign line_done   = (r_state == S_DONE);
    assign buf_wr_en   = r_buf_wr_en;
    assign buf_wr_data = r_buf_wr_data;
    assign rd_err      = r_rd_err;
    assign req_miss    = r_req_miss;

    assign axi.araddr  = r_araddr;
    assign axi.arlen   = 8'(BURST_LEN - 1);
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = (r_state == S_DATA);

endmodule
`default_nettype wire

// File: tb/tb_axi_line_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axi_line_fetch
//  Description : Self-checking bench for axi_line_fetch: table of line
//                fetches plus hand-written abort / miss / frame sequences.
//                A small frame height is used so that row wrap is reached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_line_fetch;

    localparam int DQ_WIDTH   = 32;
    localparam int ADDR_WIDTH = 28;
    localparam int DATA_W     = DQ_WIDTH * 8;
    localparam int H_HEIGHT   = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  frame_start = 1'b0;
    logic                  line_req = 1'b0;
    logic [1:0]            channel_sel = 2'd0;
    logic                  axi_wr_buf_wait = 1'b0;
    logic                  line_busy;
    logic                  line_done;
    logic                  buf_wr_en;
    logic [DATA_W-1:0]     buf_wr_data;
    logic                  rd_err;
    logic                  req_miss;
    logic [7:0]            err_cnt;

    axi_line_fetch_if #(.DQ_WIDTH(DQ_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) axi_bus ();

    axi_line_fetch #(
        .DQ_WIDTH   (DQ_WIDTH),
        .H_WIDTH    (1280),
        .H_HEIGHT   (H_HEIGHT),
        .BURST_LEN  (16),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CH_STRIDE  (28'h080_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .line_req        (line_req),
        .channel_sel     (channel_sel),
        .axi_wr_buf_wait (axi_wr_buf_wait),
        .line_busy       (line_busy),
        .line_done       (line_done),
        .buf_wr_en       (buf_wr_en),
        .buf_wr_data     (buf_wr_data),
        .rd_err          (rd_err),
        .req_miss        (req_miss),
        .err_cnt         (err_cnt),
        .axi             (axi_bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ar_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [ADDR_WIDTH-1:0] exp_ar_q[$];
    logic [DATA_W-1:0]     exp_q[$];

    bit active     = 1'b0;
    bit gaps       = 1'b0;
    int beat_no    = 0;
    int cur_burst  = 0;
    int err_burst  = -1;
    int err_beat   = -1;

    typedef struct {
        logic [1:0]            ch;
        int                    wait_cyc;
        bit                    gaps;
        logic [ADDR_WIDTH-1:0] first;
        int                    err_beat;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // DDR slave model: accepts AR, returns 16 random beats per burst and
    // records every delivered beat in the expected-write queue.
    initial begin
        axi_bus.arready = 1'b1;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rlast   = 1'b0;
        axi_bus.rresp   = 2'b00;
        axi_bus.rdata   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                axi_bus.rvalid = 1'b0;
                axi_bus.rlast  = 1'b0;
            end else begin
                if (active && (!gaps || ($urandom_range(0, 2) != 0))) begin
                    logic [DATA_W-1:0] d;
                    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
                    axi_bus.rvalid = 1'b1;
                    axi_bus.rdata  = d;
                    axi_bus.rlast  = (beat_no == 15);
                    axi_bus.rresp  = ((cur_burst == err_burst) && (beat_no == err_beat)) ? 2'b10 : 2'b00;
                    checks++;
                    if (!axi_bus.rready) begin
                        errors++;
                        $display("FAIL rready: actual=0 required=1 while data pending");
                    end else begin
                        exp_q.push_back(d);
                        beat_no++;
                        if (beat_no == 16) active = 1'b0;
                    end
                end else begin
                    axi_bus.rvalid = 1'b0;
                    axi_bus.rlast  = 1'b0;
                    axi_bus.rresp  = 2'b00;
                end
                if (axi_bus.arvalid && axi_bus.arready) begin
                    if (exp_ar_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ar_unexpected: actual=%0h required=none", axi_bus.araddr);
                    end else begin
                        check("araddr", DATA_W'(axi_bus.araddr), DATA_W'(exp_ar_q.pop_front()));
                    end
                    check("arlen", DATA_W'(axi_bus.arlen), DATA_W'(15));
                    cur_burst = ar_cnt;
                    ar_cnt++;
                    active  = 1'b1;
                    beat_no = 0;
                end
            end
        end
    end

    // Buffer-side monitor: every write is popped against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (buf_wr_en) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: actual=%0h required=none", buf_wr_data);
                    end else begin
                        check("buf_wr_data", buf_wr_data, exp_q.pop_front());
                    end
                end
                if (line_done) done_cnt++;
            end
        end
    end

    task automatic wait_done(input string tag);
        int budget = 0;
        while ((done_cnt == 0) && (budget < 3000)) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: actual=0 required=1 line_done", tag);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_line(input string tag, input logic [1:0] ch, input int wait_cyc,
                            input bit use_gaps, input logic [ADDR_WIDTH-1:0] first,
                            input int err_beat_i, input bit extra_req, input bit with_fs);
        ar_cnt = 0; wr_cnt = 0; done_cnt = 0;
        gaps = use_gaps;
        err_burst = (err_beat_i >= 0) ? 0 : -1;
        err_beat  = err_beat_i;
        for (int k = 0; k < 5; k++) exp_ar_q.push_back(first + ADDR_WIDTH'(k * 512));
        channel_sel     = ch;
        line_req        = 1'b1;
        frame_start     = with_fs;
        axi_wr_buf_wait = (wait_cyc > 0);
        @(negedge clk);
        line_req    = 1'b0;
        frame_start = 1'b0;
        channel_sel = ~ch;
        check({tag, "_busy"}, DATA_W'(line_busy), DATA_W'(1));
        if (wait_cyc > 0) begin
            int hi = 0;
            for (int k = 0; k < wait_cyc; k++) begin
                if (axi_bus.arvalid) hi++;
                @(negedge clk);
            end
            axi_wr_buf_wait = 1'b0;
            check({tag, "_arvalid_in_wait"}, DATA_W'(hi), DATA_W'(0));
            @(negedge clk);
            check({tag, "_arvalid_after_wait"}, DATA_W'(axi_bus.arvalid), DATA_W'(1));
        end
        if (extra_req) begin
            repeat (10) @(negedge clk);
            line_req = 1'b1;
            @(negedge clk);
            line_req = 1'b0;
        end
        wait_done(tag);
        check({tag, "_ar_cnt"}, DATA_W'(ar_cnt), DATA_W'(5));
        check({tag, "_wr_cnt"}, DATA_W'(wr_cnt), DATA_W'(80));
        check({tag, "_done_cnt"}, DATA_W'(done_cnt), DATA_W'(1));
        check({tag, "_busy_end"}, DATA_W'(line_busy), DATA_W'(0));
        check({tag, "_ar_left"}, DATA_W'(exp_ar_q.size()), DATA_W'(0));
        exp_ar_q.delete();
        err_burst = -1; err_beat = -1; gaps = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_err_cnt;
`ifdef AXI_LINE_FETCH_ERR_CNT_EN
        exp_err_cnt = 8'd1;
`else
        exp_err_cnt = 8'd0;
`endif
        // ch, wait, gaps, first address, error beat (burst 0)
        tbl[0] = '{2'd1,  0, 1'b0, 28'h080_0000, -1};
        tbl[1] = '{2'd1,  0, 1'b0, 28'h080_0A00, -1};
        tbl[2] = '{2'd2, 50, 1'b0, 28'h100_1400, -1};
        tbl[3] = '{2'd0,  0, 1'b1, 28'h000_1E00, -1};
        tbl[4] = '{2'd3,  0, 1'b0, 28'h180_2800, -1};
        tbl[5] = '{2'd1,  0, 1'b1, 28'h080_3200, -1};
        tbl[6] = '{2'd1,  0, 1'b0, 28'h080_0000, -1};
        tbl[7] = '{2'd2,  0, 1'b0, 28'h100_0A00,  7};

        repeat (3) @(negedge clk);
        check("rst_line_busy",   DATA_W'(line_busy), DATA_W'(0));
        check("rst_line_done",   DATA_W'(line_done), DATA_W'(0));
        check("rst_buf_wr_en",   DATA_W'(buf_wr_en), DATA_W'(0));
        check("rst_buf_wr_data", buf_wr_data, '0);
        check("rst_araddr",      DATA_W'(axi_bus.araddr), DATA_W'(0));
        check("rst_arvalid",     DATA_W'(axi_bus.arvalid), DATA_W'(0));
        check("rst_rready",      DATA_W'(axi_bus.rready), DATA_W'(0));
        check("rst_arlen",       DATA_W'(axi_bus.arlen), DATA_W'(15));
        check("rst_rd_err",      DATA_W'(rd_err), DATA_W'(0));
        check("rst_req_miss",    DATA_W'(req_miss), DATA_W'(0));
        check("rst_err_cnt",     DATA_W'(err_cnt), DATA_W'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_line($sformatf("line%0d", i), tbl[i].ch, tbl[i].wait_cyc, tbl[i].gaps,
                     tbl[i].first, tbl[i].err_beat, 1'b0, 1'b0);
            if (i == 6) begin
                check("rd_err_clean", DATA_W'(rd_err), DATA_W'(0));
            end
        end
        check("rd_err_set", DATA_W'(rd_err), DATA_W'(1));
        check("err_cnt_one", DATA_W'(err_cnt), DATA_W'(exp_err_cnt));

        // frame_start during the third burst of a channel-0, row-2 line
        ar_cnt = 0; wr_cnt = 0; done_cnt = 0;
        exp_ar_q.push_back(28'h000_1400);
        exp_ar_q.push_back(28'h000_1600);
        exp_ar_q.push_back(28'h000_1800);
        channel_sel = 2'd0;
        line_req = 1'b1;
        @(negedge clk);
        line_req = 1'b0;
        begin
            int budget = 0;
            while ((wr_cnt < 40) && (budget < 3000)) begin
                @(negedge clk);
                budget++;
            end
            checks++;
            if (wr_cnt < 40) begin
                errors++;
                $display("FAIL abort_reach_burst3: actual=%0d required=40 writes", wr_cnt);
            end
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_done("abort");
        check("abort_ar_cnt",   DATA_W'(ar_cnt), DATA_W'(3));
        check("abort_wr_cnt",   DATA_W'(wr_cnt), DATA_W'(48));
        check("abort_done_cnt", DATA_W'(done_cnt), DATA_W'(1));
        check("abort_ar_left",  DATA_W'(exp_ar_q.size()), DATA_W'(0));
        check("abort_err_cnt",  DATA_W'(err_cnt), DATA_W'(0));
        check("abort_rd_err",   DATA_W'(rd_err), DATA_W'(1));
        exp_ar_q.delete();

        run_line("post_frame", 2'd0, 0, 1'b0, 28'h000_0000, -1, 1'b0, 1'b0);

        check("miss_before", DATA_W'(req_miss), DATA_W'(0));
        run_line("miss", 2'd3, 0, 1'b0, 28'h180_0A00, -1, 1'b1, 1'b0);
        check("miss_after", DATA_W'(req_miss), DATA_W'(1));

        // line_req together with frame_start in IDLE fetches row 0
        run_line("req_fs", 2'd1, 0, 1'b0, 28'h080_0000, -1, 1'b0, 1'b1);
        check("req_fs_rd_err", DATA_W'(rd_err), DATA_W'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
